// File: rtl/lut_eval.sv
// Streaming multi-channel truth-table evaluator with rewritable tables and a 2-entry output FIFO.
// Optional accepted-input counter (eval_cnt) is enabled by defining LUT_EVAL_STATS_EN.
module lut_eval #(
    parameter int IN_W = 4,
    parameter int CH   = 1,
    parameter logic [CH*(2**IN_W)-1:0] INIT = {CH{16'hD073}},
    localparam int CHW = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic            clk,
    input  logic            areset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IN_W-1:0] x,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [CH-1:0]   f,
    input  logic            flush,
    input  logic            wr_en,
    input  logic [CHW-1:0]  wr_ch,
    input  logic [IN_W-1:0] wr_addr,
    input  logic            wr_bit
`ifdef LUT_EVAL_STATS_EN
    ,
    output logic [15:0]     eval_cnt
`endif
);

    localparam int DEPTH = 2**IN_W;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [DEPTH-1:0] tbl_q [CH];

    logic [1:0]    state_q, state_d;
    logic          in_ready_q, in_ready_d;
    logic [CH-1:0] head_q, head_d;
    logic [CH-1:0] tail_q, tail_d;
    logic [CH-1:0] lookup;
    logic          push;
    logic          pop;

    // Table storage: reset loads INIT, a write to a non-existent channel matches no row.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            for (int c = 0; c < CH; c++) begin
                tbl_q[c] <= INIT[c*DEPTH +: DEPTH];
            end
        end else if (wr_en) begin
            for (int c = 0; c < CH; c++) begin
                if (wr_ch == CHW'(c)) begin
                    tbl_q[c][wr_addr] <= wr_bit;
                end
            end
        end
    end

    always_comb begin
        lookup = '0;
        for (int c = 0; c < CH; c++) begin
            lookup[c] = tbl_q[c][x];
        end
    end

    assign out_valid = (state_q != ST_EMPTY);
    assign in_ready  = in_ready_q;
    assign f         = head_q;
    assign push      = in_valid && in_ready_q && !flush;
    assign pop       = out_valid && out_ready;

    // Head is always the oldest result; tail only holds the second entry while FULL.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    head_d  = lookup;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (push && pop) begin
                    head_d = lookup;
                end else if (push) begin
                    tail_d  = lookup;
                    state_d = ST_FULL;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    head_d  = tail_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) begin
            state_d = ST_EMPTY;
        end
        in_ready_d = (state_d != ST_FULL);
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
            head_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            head_q     <= head_d;
        end
    end

    // Second slot is never observed before being written, so it needs no reset.
    always_ff @(posedge clk) begin
        tail_q <= tail_d;
    end

`ifdef LUT_EVAL_STATS_EN
    logic [15:0] cnt_q, cnt_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        cnt_d = cnt_q;
        if (push) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign eval_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_lut_eval.sv
// Directed self-checking bench for lut_eval: a CH=1 default instance and a CH=2 instance.
module tb_lut_eval;

    logic clk;
    logic areset;

    logic       v1, ir1, ov1, or1, fl1, we1, wch1, wb1;
    logic [3:0] x1, wa1;
    logic [0:0] f1;
    logic       v2, ir2, ov2, or2, fl2, we2, wch2, wb2;
    logic [3:0] x2, wa2;
    logic [1:0] f2;
`ifdef LUT_EVAL_STATS_EN
    logic [15:0] cnt1, cnt2;
`endif

    int checks;
    int fails;

    lut_eval dut1 (
        .clk(clk), .areset(areset), .in_valid(v1), .in_ready(ir1), .x(x1),
        .out_valid(ov1), .out_ready(or1), .f(f1), .flush(fl1), .wr_en(we1),
        .wr_ch(wch1), .wr_addr(wa1), .wr_bit(wb1)
`ifdef LUT_EVAL_STATS_EN
        , .eval_cnt(cnt1)
`endif
    );

    lut_eval #(.IN_W(4), .CH(2), .INIT({16'hFFFF, 16'hD073})) dut2 (
        .clk(clk), .areset(areset), .in_valid(v2), .in_ready(ir2), .x(x2),
        .out_valid(ov2), .out_ready(or2), .f(f2), .flush(fl2), .wr_en(we2),
        .wr_ch(wch2), .wr_addr(wa2), .wr_bit(wb2)
`ifdef LUT_EVAL_STATS_EN
        , .eval_cnt(cnt2)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        #1;
        checks++;
        if (ir1 !== 1'b1 || ov1 !== 1'b0 || f1 !== 1'b0) begin
            $display("FAIL reset_ch1: in_ready=%b out_valid=%b f=%b, required 1 0 0", ir1, ov1, f1);
            fails++;
        end
        checks++;
        if (ir2 !== 1'b1 || ov2 !== 1'b0 || f2 !== 2'b00) begin
            $display("FAIL reset_ch2: in_ready=%b out_valid=%b f=%b, required 1 0 00", ir2, ov2, f2);
            fails++;
        end
`ifdef LUT_EVAL_STATS_EN
        checks++;
        if (cnt1 !== 16'h0000) begin
            $display("FAIL reset_cnt: eval_cnt=%h, required 0000", cnt1);
            fails++;
        end
`endif
        tick();
        areset = 1'b0;
    endtask

    task automatic test_stream();
        logic [15:0] tt;
        tt = 16'b1101_0000_0111_0011;
        or1 = 1'b1;
        v1  = 1'b1;
        for (int k = 0; k < 16; k++) begin
            x1 = 4'(k);
            checks++;
            if (ir1 !== 1'b1) begin
                $display("FAIL stream_ready k=%0d: in_ready=%b, required 1", k, ir1);
                fails++;
            end
            tick();
            checks++;
            if (ov1 !== 1'b1 || f1 !== tt[k]) begin
                $display("FAIL stream_f k=%0d: out_valid=%b f=%b, required 1 %b", k, ov1, f1, tt[k]);
                fails++;
            end
        end
        v1 = 1'b0;
        tick();
        checks++;
        if (ov1 !== 1'b0) begin
            $display("FAIL stream_drain: out_valid=%b, required 0", ov1);
            fails++;
        end
    endtask

    task automatic test_back_to_back();
        or1 = 1'b0;
        v1  = 1'b1;
        x1  = 4'd2;
        tick();
        checks++;
        if (ir1 !== 1'b1 || ov1 !== 1'b1 || f1 !== 1'b0) begin
            $display("FAIL bp_first: in_ready=%b out_valid=%b f=%b, required 1 1 0", ir1, ov1, f1);
            fails++;
        end
        x1 = 4'd4;
        tick();
        checks++;
        if (ir1 !== 1'b0 || ov1 !== 1'b1 || f1 !== 1'b0) begin
            $display("FAIL bp_full: in_ready=%b out_valid=%b f=%b, required 0 1 0", ir1, ov1, f1);
            fails++;
        end
        x1 = 4'd5;
        tick();
        checks++;
        if (ir1 !== 1'b0 || f1 !== 1'b0) begin
            $display("FAIL bp_hold: in_ready=%b f=%b, required 0 0", ir1, f1);
            fails++;
        end
        or1 = 1'b1;
        tick();
        checks++;
        if (ir1 !== 1'b1 || ov1 !== 1'b1 || f1 !== 1'b1) begin
            $display("FAIL bp_pop1: in_ready=%b out_valid=%b f=%b, required 1 1 1 (x=4)", ir1, ov1, f1);
            fails++;
        end
        tick();
        checks++;
        if (ov1 !== 1'b1 || f1 !== 1'b1) begin
            $display("FAIL bp_pop2: out_valid=%b f=%b, required 1 1 (x=5)", ov1, f1);
            fails++;
        end
        v1 = 1'b0;
        tick();
        checks++;
        if (ov1 !== 1'b0) begin
            $display("FAIL bp_drain: out_valid=%b, required 0 (no duplicate)", ov1);
            fails++;
        end
    endtask

    task automatic test_write_same_cycle();
        or1  = 1'b1;
        v1   = 1'b1;
        x1   = 4'd3;
        we1  = 1'b1;
        wch1 = 1'b0;
        wa1  = 4'd3;
        wb1  = 1'b1;
        tick();
        we1 = 1'b0;
        checks++;
        if (f1 !== 1'b0) begin
            $display("FAIL wr_old: f=%b, required 0", f1);
            fails++;
        end
        tick();
        checks++;
        if (f1 !== 1'b1) begin
            $display("FAIL wr_new: f=%b, required 1", f1);
            fails++;
        end
        v1   = 1'b0;
        we1  = 1'b1;
        wch1 = 1'b1;
        wa1  = 4'd0;
        wb1  = 1'b0;
        tick();
        we1 = 1'b0;
        v1  = 1'b1;
        x1  = 4'd0;
        tick();
        checks++;
        if (f1 !== 1'b1) begin
            $display("FAIL wr_bad_ch: f=%b, required 1 (write to channel 1 ignored)", f1);
            fails++;
        end
        v1 = 1'b0;
        tick();
    endtask

    task automatic test_ch2_reset();
        or2 = 1'b1;
        v2  = 1'b1;
        x2  = 4'd2;
        tick();
        checks++;
        if (f2 !== 2'b10) begin
            $display("FAIL ch2_x2: f=%b, required 10", f2);
            fails++;
        end
        v2   = 1'b0;
        we2  = 1'b1;
        wch2 = 1'b1;
        wa2  = 4'd7;
        wb2  = 1'b0;
        tick();
        we2 = 1'b0;
        or2 = 1'b0;
        v2  = 1'b1;
        x2  = 4'd7;
        tick();
        checks++;
        if (f2 !== 2'b00) begin
            $display("FAIL ch2_written: f=%b, required 00", f2);
            fails++;
        end
        x2 = 4'd0;
        tick();
        checks++;
        if (ir2 !== 1'b0 || ov2 !== 1'b1) begin
            $display("FAIL ch2_full: in_ready=%b out_valid=%b, required 0 1", ir2, ov2);
            fails++;
        end
        areset = 1'b1;
        #1;
        checks++;
        if (ov2 !== 1'b0 || ir2 !== 1'b1) begin
            $display("FAIL ch2_async_rst: out_valid=%b in_ready=%b, required 0 1", ov2, ir2);
            fails++;
        end
        areset = 1'b0;
        #1;
        or2 = 1'b1;
        x2  = 4'd7;
        tick();
        checks++;
        if (ov2 !== 1'b1 || f2 !== 2'b10) begin
            $display("FAIL ch2_init_restored: out_valid=%b f=%b, required 1 10", ov2, f2);
            fails++;
        end
        v2 = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        or1 = 1'b0;
        v1  = 1'b1;
        x1  = 4'd0;
        tick();
        x1 = 4'd1;
        tick();
        checks++;
        if (ir1 !== 1'b0) begin
            $display("FAIL flush_pre_full: in_ready=%b, required 0", ir1);
            fails++;
        end
        fl1 = 1'b1;
        x1  = 4'd4;
        tick();
        checks++;
        if (ov1 !== 1'b0 || ir1 !== 1'b1) begin
            $display("FAIL flush_full: out_valid=%b in_ready=%b, required 0 1", ov1, ir1);
            fails++;
        end
        x1 = 4'd2;
        tick();
        fl1 = 1'b0;
        checks++;
        if (ov1 !== 1'b0) begin
            $display("FAIL flush_drop: out_valid=%b, required 0", ov1);
            fails++;
        end
`ifdef LUT_EVAL_STATS_EN
        checks++;
        if (cnt1 !== 16'd2) begin
            $display("FAIL flush_cnt: eval_cnt=%0d, required 2", cnt1);
            fails++;
        end
`endif
        or1 = 1'b1;
        x1  = 4'd12;
        tick();
        v1 = 1'b0;
        checks++;
        if (ov1 !== 1'b1 || f1 !== 1'b1) begin
            $display("FAIL flush_after: out_valid=%b f=%b, required 1 1", ov1, f1);
            fails++;
        end
        tick();
        checks++;
        if (ov1 !== 1'b0) begin
            $display("FAIL flush_no_ghost: out_valid=%b, required 0", ov1);
            fails++;
        end
`ifdef LUT_EVAL_STATS_EN
        checks++;
        if (cnt1 !== 16'd3) begin
            $display("FAIL flush_cnt_after: eval_cnt=%0d, required 3", cnt1);
            fails++;
        end
`endif
    endtask

`ifdef LUT_EVAL_STATS_EN
    task automatic test_saturate();
        areset = 1'b1;
        tick();
        areset = 1'b0;
        or1 = 1'b1;
        v1  = 1'b1;
        x1  = 4'd0;
        repeat (65534) tick();
        checks++;
        if (cnt1 !== 16'hFFFE) begin
            $display("FAIL sat_pre: eval_cnt=%h, required FFFE", cnt1);
            fails++;
        end
        repeat (6) tick();
        checks++;
        if (cnt1 !== 16'hFFFF) begin
            $display("FAIL sat_hold: eval_cnt=%h, required FFFF", cnt1);
            fails++;
        end
        v1 = 1'b0;
        tick();
    endtask
`endif

    initial begin
        checks = 0;
        fails  = 0;
        areset = 1'b0;
        v1 = 1'b0; or1 = 1'b0; fl1 = 1'b0; we1 = 1'b0; wch1 = 1'b0; wb1 = 1'b0;
        x1 = '0;   wa1 = '0;
        v2 = 1'b0; or2 = 1'b0; fl2 = 1'b0; we2 = 1'b0; wch2 = 1'b0; wb2 = 1'b0;
        x2 = '0;   wa2 = '0;
        #2;
        test_reset();
        test_stream();
        test_back_to_back();
        test_write_same_cycle();
        test_ch2_reset();
        test_flush();
`ifdef LUT_EVAL_STATS_EN
        test_saturate();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/lut_eval.md
# lut_eval

Registered, streaming truth-table evaluator. It generalises our fixed 4-input combinational Karnaugh-map function into a parametrised block with three additions:
- CH independent functions over an IN_W-bit input.
- Run-time rewritable tables.
- A valid/ready input and output with a 2-entry output buffer.

It sits between a producer of x codes and a downstream consumer that may stall.

## Interface
Parameters:
- IN_W, 4: input code width; each table holds 2^IN_W bits.
- CH, 1: number of functions (output bits) evaluated per input.
- INIT, {CH{16'hD073}} (CH*2^IN_W bits): reset table contents.
  - Channel c, code k is bit c*2^IN_W+k.
  - The default is f=1 for codes 0,1,4,5,6,12,14,15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- areset  in  1  asynchronous, active-high reset.
- in_valid  in  1  x is presented.
- in_ready  out  1  block accepts x this cycle.
- x  in  IN_W  input code.
- out_valid  out  1  f holds a result.
- out_ready  in  1  consumer takes f this cycle.
- f  out  CH  result, bit c = table[c][x].
- flush  in  1  synchronous; discards buffered results.
- wr_en  in  1  table bit write strobe.
- wr_ch  in  max(1,$clog2(CH))  channel to write.
- wr_addr  in  IN_W  code to write.
- wr_bit  in  1  new table bit.
- eval_cnt  out  16  accepted-input count; present only with LUT_EVAL_STATS_EN.

## Operation
- **Storage:** CH x 2^IN_W bit table, loaded with INIT on areset.
- **Table write:**
  - On the clock edge with wr_en=1, table[wr_ch][wr_addr] takes the value wr_bit.
  - wr_ch >= CH is ignored.
- **Accept:** an input is accepted when in_valid && in_ready. The CH-bit result table[*][x] is computed at that moment and pushed into the output buffer.
- **Write vs. lookup in the same cycle:** the lookup uses the table value from before the edge (old data). The write is seen by inputs accepted from the next cycle onward.
- **Output buffer:** 2-entry FIFO with states EMPTY, ONE, FULL.
  - EMPTY: push -> ONE.
  - ONE: push only -> FULL; pop only -> EMPTY; push+pop -> ONE.
  - FULL: pop -> ONE. No push is possible because in_ready=0.
- **Handshake signals:**
  - in_ready = (state != FULL). It is registered and has no combinational dependence on out_ready.
  - out_valid = (state != EMPTY).
  - f = head entry, stable while out_valid && !out_ready.
- **Flush:**
  - flush=1 sets the state to EMPTY at the edge.
  - Flush has priority: any input accepted in that same cycle is dropped.
  - The table and eval_cnt are unaffected.
- **Reset:**
  - Reset mid-operation discards buffered results immediately.
  - All table writes since the last reset are lost.

## Timing
- Reset values: in_ready=1, out_valid=0, f=0, eval_cnt=0; table=INIT.
- Latency: input accepted at edge k -> out_valid=1 with its f after edge k (1 cycle).
- Throughput: 1 result/cycle while out_ready=1.
- Results leave in acceptance order. None are lost or duplicated except by flush or reset.
- With out_ready held 0: two inputs are accepted, then in_ready drops after the second acceptance edge.
- in_ready returns to 1 the cycle after the first pop.

## Configuration
- LUT_EVAL_STATS_EN defined:
  - Adds port eval_cnt, 16-bit.
  - Increments by 1 on each accepted, non-flushed input.
  - Saturates at 16'hFFFF.
  - Cleared only by areset.
- Not defined: port and counter absent. All other behaviour is identical.

## Test plan
- Reset, CH=1 defaults; stream x=0..15 with out_ready=1 -> f sequence 1,1,0,0,1,1,1,0,0,0,0,0,1,0,1,1, each 1 cycle after acceptance; in_ready stays 1.
- out_ready=0, offer x=2,x=4,x=5 back-to-back -> x=2,4 accepted, in_ready=0 at third; then out_ready=1 -> f=0,1 then (x=5 accepted) 1, in order.
- Same cycle: wr_en=1, wr_addr=3, wr_bit=1, accept x=3 -> f=0; next accept of x=3 -> f=1.
- CH=2, INIT channel 1 = 16'hFFFF; x=2 -> f=2'b10; areset mid-stream with FULL buffer -> out_valid=0, in_ready=1 asynchronously, table back to INIT.
- flush with buffer FULL and in_valid=1 -> next cycle out_valid=0, dropped input never appears; with LUT_EVAL_STATS_EN, eval_cnt unchanged by the dropped input.
- LUT_EVAL_STATS_EN: force 65540 accepts -> eval_cnt=16'hFFFF, holds.
